// File: rtl/mill_pkg.sv
// mill_pkg: shared front-end types and constants.
// Fetch FSM states, reset PC default, instruction size.
package mill_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/pc_fetch_buf.sv
// pc_fetch_buf: IF->ID output register (valid + {pc, instr}).
// Ports: clk, rst_n (sync, active low), load/clear, ld (bundle), if_valid/if_pc/if_instr.
module pc_fetch_buf
  import mill_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  if_id_t          ld,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  // clear wins over load so a redirect always
  // kills whatever would otherwise be presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (clear) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= ld.pc;
      if_instr <= ld.instr;
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: PC owner, imem req/ack fetch FSM, IF->ID valid/ready.
// Ports: clk, rst_n, redirect_*, imem_*, if_*; PC_MISALIGN_TRAP_EN adds misalign_trap/misalign_addr.
module pc_fetch_gen
  import mill_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drain_addr;
  logic            kill;

  logic   ack;
  logic   hs;
  logic   misalign;
  logic   buf_load;
  logic   buf_clear;
  if_id_t buf_ld;

  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  // The request in flight when a redirect hit must keep its address.
  assign imem_addr = kill ? drain_addr : pc;

  assign ack = imem_ack && imem_req;
  assign hs  = if_valid && if_ready;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign buf_load  = (state == S_FETCH) && !kill && ack && !redirect_valid;
  assign buf_clear = redirect_valid || ((state == S_HOLD) && hs);
  assign buf_ld    = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      kill       <= 1'b0;
    end else if (misalign) begin
      state <= S_HALT;
      kill  <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
      case (state)
        S_FETCH: begin
          if (!ack) begin
            state      <= S_DRAIN;
            kill       <= 1'b1;
            drain_addr <= pc;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            state <= S_FETCH;
            kill  <= 1'b0;
          end
        end
        S_HOLD:  state <= S_FETCH;
        S_HALT:  state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (ack) begin
            pc    <= pc_next(pc);
            state <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            state <= S_FETCH;
            kill  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hs) state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_trap <= misalign;
      if (misalign) misalign_addr <= redirect_target;
    end
  end
`endif

  pc_fetch_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .ld       (buf_ld),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr)
  );

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
- Front-end PC owner. Holds the architectural PC and issues instruction fetches to the instruction memory over a req/ack handshake.
- Hands {pc, instr} pairs to decode over a valid/ready handshake.
- Accepts redirects (taken branch / JAL / JALR targets) from execute.
- Writer side of the PC that downstream operand selection and branch-target arithmetic consume.

Parameters:
- RESET_PC, 32'h8000_0000: PC fetched first after reset.
- XLEN, 32: address/data width. Only 32 is supported.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_target  in  XLEN  new PC
- imem_req  out  1  fetch request, held high until imem_ack
- imem_addr  out  XLEN  fetch address, stable while imem_req high
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle only
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  if_pc/if_instr valid to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  XLEN  PC of presented instruction
- if_instr  out  32  presented instruction

Behaviour:
Reset:
- rst_n low at a clock edge: state = S_FETCH, pc = RESET_PC, if_valid = 0, if_pc = 0, if_instr = 0, kill = 0.
- imem_req = 1 and imem_addr = RESET_PC in the first cycle after reset deasserts.
- Reset mid-transaction abandons it; the memory side must tolerate a dropped req.

States:
- S_FETCH: imem_req = 1, imem_addr = pc.
  - On imem_ack without kill: if_pc <= pc, if_instr <= imem_rdata, if_valid <= 1, pc <= pc + 4, go S_HOLD.
- S_DRAIN: imem_req = 1, imem_addr = latched old address; data will be discarded.
  - On imem_ack: go S_FETCH with the already-updated pc.
- S_HOLD: imem_req = 0, outputs stable while if_valid && !if_ready.
  - On if_valid && if_ready: if_valid <= 0, go S_FETCH next cycle.
  - Throughput is one instruction per 2 cycles minimum; no bypass.

Redirect (highest priority, any state):
- pc <= redirect_target; if_valid <= 0 the next cycle, even if if_ready is also high (handshake counts as not taken).
- S_FETCH without imem_ack: cannot withdraw the request. Go S_DRAIN, keeping imem_addr at the old pc until ack.
- S_FETCH with imem_ack in the same cycle: discard the data, stay S_FETCH with the new pc.
- S_DRAIN: only update pc; remain S_DRAIN.
- S_HOLD: drop the held instruction, go S_FETCH.

Arithmetic:
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- redirect_target is taken verbatim; low 2 bits are kept in pc.

imem_ack while imem_req is low is ignored.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- With the macro defined:
  - Adds outputs misalign_trap (1) and misalign_addr (XLEN).
  - A redirect with redirect_target[1:0] != 0 does not change pc. Instead it pulses misalign_trap high for one cycle and sets misalign_addr = target.
  - The block then enters S_HALT: no fetches, if_valid = 0, until reset or a subsequent aligned redirect, which resumes at S_FETCH.
  - misalign_trap/misalign_addr reset to 0.
- Without the macro: the ports are absent and no check is made.

Decomposition:
- Shared package mill_pkg holds:
  - Fetch state enum typedef (S_FETCH, S_DRAIN, S_HOLD, S_HALT).
  - Default RESET_PC constant.
  - INSTR_BYTES = 4.
- One natural sub-module: pc_fetch_buf, the if_pc/if_instr/if_valid output register with load/clear/hold control.
- The top keeps the FSM, pc, and kill logic.

Test Plan:
1. Reset release, imem_ack 1 cycle after each req, if_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008 in order; each if_pc matches its address; one instruction per ≥2 cycles.
2. if_ready=0 for 5 cycles while if_valid=1 -> if_pc/if_instr stable, imem_req=0 throughout; accepted on the cycle if_ready rises.
3. Redirect to 8000_0100 while a req to 8000_0008 awaits ack (ack 3 cycles later) -> imem_addr stays 8000_0008 until ack, data dropped (if_valid stays 0), next req = 8000_0100.
4. Redirect to 8000_0200 on the same cycle as imem_ack, and separately during S_HOLD with if_ready=1 -> no instruction delivered; next req = 8000_0200.
5. Redirect to FFFF_FFFC, ack -> next fetch address 0000_0000.
6. (PC_MISALIGN_TRAP_EN) Redirect to 8000_0102 -> misalign_trap one-cycle pulse, misalign_addr=8000_0102, no further imem_req; then aligned redirect to 8000_0000 -> fetching resumes there.
